div_unit: RTL
=============

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 clk  input  1  pipeline clock; all state updates on the rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-003 start  input  1  EXE stage holds high while a DIV/DIVU occupies EXE.
REQ-004 annul  input  1  cancel in-flight division (flush); overrides start.
REQ-005 signed_div  input  1  1 = DIV (two's complement), 0 = DIVU.
REQ-006 opdata1  input  32  dividend (rs).
REQ-007 opdata2  input  32  divisor (rt).
REQ-008 result  output  64  {remainder[63:32], quotient[31:0]} for HI/LO.
REQ-009 ready  output  1  result valid.
REQ-010 stall_req  output  1  request to the stall controller's EXE stall input.

Function
REQ-011 States: IDLE, BYZERO (only with the Configuration macro), ON, END.
REQ-012 IDLE, start=1, annul=0: latch |opdata1|, |opdata2| (magnitudes only if signed_div), latch both sign bits, clear the iteration counter, go to ON.
REQ-013 ON: one restoring shift-subtract step per cycle; quotient bit = 1 when the partial remainder is at least the divisor; 32 steps total.
REQ-014 The edge performing step 32 registers result, sets ready=1, and enters END; ready first rises 33 edges after start is first sampled (sampling edge = edge 1).
REQ-015 Sign fix when signed_div: negate quotient if latched signs differ; remainder takes the dividend sign.
REQ-016 0x80000000 / 0xFFFFFFFF signed yields quotient 0x80000000, remainder 0; no trap.
REQ-017 END: result and ready hold while start=1; start=0 goes to IDLE with ready=0 and result=0 on the next edge.
REQ-018 annul=1 in any state goes to IDLE on the next edge with ready=0 and result=0; no result is ever produced for the annulled operation.
REQ-019 Operand changes after the start sample have no effect until the next IDLE-to-ON entry.
REQ-020 stall_req = start & ~ready & ~annul, combinational; it is 0 whenever start=0.
REQ-021 A new start is accepted only from IDLE; a back-to-back divide requires one cycle with start=0.

Reset
REQ-022 rst=0 immediately forces state IDLE, counter 0, result 0, ready 0; stall_req follows REQ-020.
REQ-023 Reset during ON or END discards the operation; after release, the unit accepts start in the first cycle.

Configuration
REQ-024 Macro DIV_BYZERO_FAST_EN: when defined, IDLE with start=1 and opdata2=0 enters BYZERO; the next edge enters END with result=0 and ready=1, so ready rises 2 edges after the start sample.
REQ-025 Without DIV_BYZERO_FAST_EN, divisor 0 runs all 32 steps.
  - Unsigned: quotient 0xFFFFFFFF, remainder = dividend.
  - Signed: result after the REQ-015 sign fix.

Structure
REQ-026 The shared package pipeline_pkg holds:
  - state encodings;
  - DIV_ITER = 32;
  - stall-vector bit indices (PC, IF, ID, EXE, MEM, WB).
REQ-027 The unit uses one combinational sub-module, div_step: inputs are the partial remainder and the divisor; outputs are the next partial remainder and the quotient bit.

Verification
REQ-028 DIVU 100/7, start held: stall_req=1 for 32 cycles; ready=1 on edge 33; result={0x00000002,0x0000000E}; stall_req=0 from then on.
REQ-029 DIV 0xFFFFFF9C(-100)/7: quotient 0xFFFFFFF2, remainder 0xFFFFFFFE; DIV 0x80000000/0xFFFFFFFF: quotient 0x80000000, remainder 0.
REQ-030 annul pulsed at step 10 of DIVU 50/5: IDLE next edge; ready never asserts; a following DIVU 50/5 returns quotient 0x0000000A, remainder 0.
REQ-031 DIVU 0x12345678/0:
  - with the macro: result 0 and ready on edge 2;
  - without it: quotient 0xFFFFFFFF, remainder 0x12345678 on edge 33.
REQ-032 rst=0 asserted mid-ON, asynchronous to clk: ready, result, and state clear with no clock edge; stall_req=0 once start drops.

Source files
------------

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared divider state encodings, iteration count and stall-vector bit indices
package pipeline_pkg;
  typedef enum logic [1:0] {IDLE, BYZERO, ON, END} div_state_e;
  localparam int DIV_ITER  = 32;
  localparam int STALL_PC  = 0;
  localparam int STALL_IF  = 1;
  localparam int STALL_ID  = 2;
  localparam int STALL_EXE = 3;
  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring shift-subtract step on the shifted partial remainder
module div_step (
  input  logic [32:0] rem_in,
  input  logic [31:0] divisor,
  output logic [31:0] rem_out,
  output logic        q_bit
);
  assign q_bit   = rem_in >= {1'b0, divisor};
  assign rem_out = q_bit ? 32'(rem_in - {1'b0, divisor}) : rem_in[31:0];
endmodule

// File: rtl/div_unit.sv
// div_unit: 32-step restoring DIV/DIVU for the EXE stage; DIV_BYZERO_FAST_EN short-cuts divide by zero
module div_unit
  import pipeline_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        annul,
  input  logic        signed_div,
  input  logic [31:0] opdata1,
  input  logic [31:0] opdata2,
  output logic [63:0] result,
  output logic        ready,
  output logic        stall_req
);
  div_state_e  state, nxt;
  logic [4:0]  cnt;
  logic [31:0] dvd, dvs, rem, rem_nx, q_fin, quo, rmd;
  logic        s1, s2, q_bit;
  div_step u_step (.rem_in({rem, dvd[31]}), .divisor(dvs), .rem_out(rem_nx), .q_bit(q_bit));
  assign q_fin     = {dvd[30:0], q_bit};
  assign quo       = (s1 ^ s2) ? -q_fin : q_fin;
  assign rmd       = s1 ? -rem_nx : rem_nx;
  assign stall_req = start & ~ready & ~annul;
  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= nxt;
  // next state; annul wins from anywhere
  always_comb begin
    nxt = state;
    if (annul) nxt = IDLE;
    else
      case (state)
`ifdef DIV_BYZERO_FAST_EN
        IDLE:    nxt = start ? ((opdata2 == '0) ? BYZERO : ON) : IDLE;
`else
        IDLE:    nxt = start ? ON : IDLE;
`endif
        BYZERO:  nxt = END;
        ON:      nxt = (cnt == 5'(DIV_ITER - 1)) ? END : ON;
        END:     nxt = start ? END : IDLE;
        default: nxt = IDLE;
      endcase
  end
  // operand latch, iteration datapath and result register; dvd doubles as the quotient shifter
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt    <= '0;
      dvd    <= '0;
      dvs    <= '0;
      rem    <= '0;
      s1     <= 1'b0;
      s2     <= 1'b0;
      result <= '0;
      ready  <= 1'b0;
    end else if (nxt == IDLE) begin
      result <= '0;
      ready  <= 1'b0;
    end else if (state == IDLE) begin
      s1  <= signed_div & opdata1[31];
      s2  <= signed_div & opdata2[31];
      dvd <= (signed_div & opdata1[31]) ? -opdata1 : opdata1;
      dvs <= (signed_div & opdata2[31]) ? -opdata2 : opdata2;
      rem <= '0;
      cnt <= '0;
    end else if (state == ON) begin
      dvd <= q_fin;
      rem <= rem_nx;
      cnt <= cnt + 5'd1;
      if (nxt == END) begin
        result <= {rmd, quo};
        ready  <= 1'b1;
      end
    end else if (state == BYZERO) begin
      result <= '0;
      ready  <= 1'b1;
    end
endmodule
